// File: rtl/aer_in_arbiter.sv
// -----------------------------------------------------------------------------
// aer_in_arbiter
//
// Merges NUM_CHANNELS asynchronous 4-phase AER input channels into one
// synchronous valid/ready output port.
//
// Each channel's request is passed through a synchronizer. The block then
// round-robin arbitrates among the channels that are pending. It captures the
// winning channel's bundled data word into a single output register. It also
// runs that channel's acknowledge through the full return-to-zero handshake.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   req            async 4-phase request, one bit per channel
//   ack            registered acknowledge, one bit per channel
//   in_data        bundled data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   channel_enable 1 = channel may be granted
//   out_valid      output word valid
//   out_ready      consumer accepts word when out_valid & out_ready
//   out_data       captured word
//   out_channel    index of the channel that produced out_data
// -----------------------------------------------------------------------------
module aer_in_arbiter #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CHANNELS-1:0]            req,
  output logic [NUM_CHANNELS-1:0]            ack,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CHANNELS-1:0]            channel_enable,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [$clog2(NUM_CHANNELS)-1:0]    out_channel
);

  localparam int CW = $clog2(NUM_CHANNELS);

  logic [NUM_CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CHANNELS-1:0] req_sync;
  logic [NUM_CHANNELS-1:0] pending;
  logic [DATA_WIDTH-1:0]   chan_data [NUM_CHANNELS];
  logic [CW-1:0]           ptr;
  logic [CW-1:0]           grant;
  logic [CW-1:0]           idx_c;
  int                      idx;
  logic                    load;

  // Unpack the flat data bus so the grant can select a word directly.
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_unpack
    assign chan_data[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Request synchronizers. Every stage is cleared by reset. That way a
  // request still held across reset is seen as a fresh rising edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= req;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign req_sync = sync_q[SYNC_STAGES-1];

  // A channel that is still acked cannot pend. This blocks any re-grant until
  // its synchronized request has returned to zero.
  assign pending = req_sync & ~ack & channel_enable;
  assign load    = (~out_valid | out_ready) & (|pending);

  // Round-robin search starting at ptr. Scan in descending offset order so
  // the last hit written is the nearest pending index at or after ptr.
  // NOTE: every output of an always_comb gets a default first; otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    grant = '0;
    idx   = 0;
    idx_c = '0;
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
      idx_c = CW'(idx);
      if (pending[idx_c]) grant = idx_c;
    end
  end

  // Output register, round-robin pointer and the acknowledge handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
      ptr         <= '0;
    end else begin
      if (load) begin
        out_valid   <= 1'b1;
        out_data    <= chan_data[grant];
        out_channel <= grant;
        ptr         <= (grant == CW'(NUM_CHANNELS - 1)) ? '0 : grant + 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // The return-to-zero takes priority. A granted channel is never acked,
      // so the two branches cannot both apply to the same bit anyway.
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (ack[i] && !req_sync[i]) begin
          ack[i] <= 1'b0;
        end else if (load && grant == CW'(i)) begin
          ack[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aer_in_arbiter.sv
// -----------------------------------------------------------------------------
// tb_aer_in_arbiter
//
// Directed self-checking bench for aer_in_arbiter with the default parameters
// (4 channels, 16-bit data, 2 synchronizer stages). Inputs change 1 ns after
// the rising edge. Outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_aer_in_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  ack;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  channel_enable;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_channel;

  int checks = 0;
  int errors = 0;

  aer_in_arbiter #(.NUM_CHANNELS(N), .DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .ack            (ack),
    .in_data        (in_data),
    .channel_enable (channel_enable),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_channel    (out_channel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick(input int n = 1);
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    req            = '0;
    in_data        = '0;
    out_ready      = 1'b1;
    channel_enable = '1;
    rst_n          = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic set_data(input int ch, input logic [DW-1:0] d);
    in_data[ch*DW +: DW] = d;
  endtask

  int sent [N];
  int rcv  [N];
  int words;
  int cycles;
  int bad;
  int exp_ch;

  initial begin
    // ---------------- reset state ----------------
    rst_n = 1'b0;
    req = '0; in_data = '0; out_ready = 1'b1; channel_enable = '1;
    #2;
    check("rst_ack", ack, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_chan", out_channel, 0);
    do_reset();

    // ---------------- single event, latency ----------------
    set_data(1, 16'h1234);
    req[1] = 1'b1;
    tick(2);                               // edges 1 and 2
    check("single_e2_valid", out_valid, 0);
    check("single_e2_ack", ack, 0);
    tick();                                // edge 3
    check("single_e3_valid", out_valid, 1);
    check("single_e3_data", out_data, 16'h1234);
    check("single_e3_chan", out_channel, 1);
    check("single_e3_ack", ack, 4'b0010);
    req[1] = 1'b0;
    tick();                                // drop edge 1: word accepted
    check("single_drain_valid", out_valid, 0);
    check("single_rtz_e1", ack, 4'b0010);
    tick();
    check("single_rtz_e2", ack, 4'b0010);
    tick();
    check("single_rtz_e3", ack, 4'b0000);
    bad = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (out_valid) bad++;
    end
    check("single_one_word", bad, 0);

    // ---------------- fairness with auto-handshake senders ----------------
    do_reset();
    for (int i = 0; i < N; i++) begin sent[i] = 0; rcv[i] = 0; end
    words = 0;
    cycles = 0;
    while (words < 40 && cycles < 2000) begin
      if (out_valid) begin
        exp_ch = words % N;
        check("fair_chan", out_channel, exp_ch);
        check("fair_data", out_data, {exp_ch[3:0], 12'(rcv[exp_ch])});
        rcv[exp_ch]++;
        words++;
      end
      for (int i = 0; i < N; i++) begin
        if (req[i] && ack[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && !ack[i] && sent[i] < 10) begin
          set_data(i, {i[3:0], 12'(sent[i])});
          req[i] = 1'b1;
          sent[i]++;
        end
      end
      tick();
      cycles++;
    end
    check("fair_words", words, 40);
    for (int i = 0; i < N; i++) check("fair_per_chan", rcv[i], 10);
    req = '0;
    tick(6);
    check("fair_settle_ack", ack, 0);
    check("fair_settle_valid", out_valid, 0);

    // ---------------- backpressure ----------------
    do_reset();
    out_ready = 1'b0;
    set_data(0, 16'hAAAA);
    req[0] = 1'b1;
    tick(3);
    check("bp_first_valid", out_valid, 1);
    check("bp_first_ack", ack, 4'b0001);
    req[0] = 1'b0;
    set_data(2, 16'hCCCC);
    req[2] = 1'b1;
    tick(5);
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_data", out_data, 16'hAAAA);
    check("bp_hold_chan", out_channel, 0);
    check("bp_hold_ack", ack, 4'b0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_swap_valid", out_valid, 1);
    check("bp_swap_data", out_data, 16'hCCCC);
    check("bp_swap_chan", out_channel, 2);
    check("bp_swap_ack", ack, 4'b0100);
    req[2] = 1'b0;
    tick(2);
    check("bp_stable_data", out_data, 16'hCCCC);
    out_ready = 1'b1;
    tick(4);

    // ---------------- channel masking ----------------
    do_reset();
    channel_enable = 4'b1011;
    set_data(2, 16'h2222);
    req[2] = 1'b1;
    bad = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (ack[2] || out_valid || out_channel == 2) bad++;
    end
    check("mask_never", bad, 0);
    channel_enable = 4'b1111;
    tick();
    check("mask_en_valid", out_valid, 1);
    check("mask_en_chan", out_channel, 2);
    check("mask_en_data", out_data, 16'h2222);
    check("mask_en_ack", ack, 4'b0100);
    req[2] = 1'b0;
    tick(4);

    // ---------------- disable mid-handshake ----------------
    do_reset();
    set_data(0, 16'h0F0F);
    req[0] = 1'b1;
    tick(3);
    check("dis_ack_up", ack, 4'b0001);
    channel_enable[0] = 1'b0;
    req[0] = 1'b0;
    tick(2);
    check("dis_ack_held", ack, 4'b0001);
    tick();
    check("dis_ack_rtz", ack, 4'b0000);
    req[0] = 1'b1;
    bad = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (ack[0] || out_valid) bad++;
    end
    check("dis_no_regrant", bad, 0);
    req[0] = 1'b0;
    channel_enable = '1;
    tick(3);

    // ---------------- async reset mid-handshake ----------------
    do_reset();
    out_ready = 1'b0;
    set_data(3, 16'h3333);
    req[3] = 1'b1;
    tick(3);
    check("arst_pre_ack", ack, 4'b1000);
    check("arst_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;                          // mid-cycle, no clock edge
    #1;
    check("arst_ack", ack, 0);
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_chan", out_channel, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(2);
    check("arst_rel_e2_valid", out_valid, 0);
    tick();
    check("arst_rel_e3_valid", out_valid, 1);
    check("arst_rel_e3_chan", out_channel, 3);
    check("arst_rel_e3_data", out_data, 16'h3333);
    check("arst_rel_e3_ack", ack, 4'b1000);
    req[3] = 1'b0;
    tick(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
